// File: rtl/quad_decoder.sv
// Quadrature A/B decoder: synchronises and glitch-filters two encoder
// phases, turns each legal Gray step into a one-cycle enable pulse plus
// direction, and keeps a wrapping position count and a sticky error flag.
module quad_decoder #(
    parameter int POS_W = 16,
    parameter int FILT  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_in,
    input  logic             b_in,
    input  logic             clr,
    output logic             en_out,
    output logic             up_dwn_n_out,
    output logic [POS_W-1:0] pos,
    output logic             err
);

    localparam logic [3:0] FILT_M1 = 4'(FILT - 1);

    // Synchroniser, filter and priming state
    logic [1:0]       sync1_q, sync1_d;
    logic [1:0]       sync2_q, sync2_d;
    logic [1:0]       vld_q, vld_d;
    logic [1:0]       filt_q, filt_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [3:0]       pcnt_q, pcnt_d;
    logic             primed_q, primed_d;

    // Decode stage (captured on the filter update event)
    logic             step_up_q, step_up_d;
    logic             step_dn_q, step_dn_d;
    logic             step_bad_q, step_bad_d;

    // Output stage
    logic             en_q, en_d;
    logic             dir_q, dir_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             err_q, err_d;

    logic             upd;
    logic             settle;
    logic [1:0]       idx_old;
    logic [1:0]       idx_new;
    logic [1:0]       idx_diff;

    // Position of a phase pair along the up sequence 00->10->11->01
    function automatic logic [1:0] gray_idx(input logic [1:0] ab);
        case (ab)
            2'b00:   gray_idx = 2'd0;
            2'b10:   gray_idx = 2'd1;
            2'b11:   gray_idx = 2'd2;
            default: gray_idx = 2'd3;
        endcase
    endfunction

    // Next-state logic for synchroniser, filter, priming, decode and outputs
    always_comb begin
        sync1_d    = {a_in, b_in};
        sync2_d    = sync1_q;
        // vld tracks how far genuine pin samples have propagated since rst,
        // so the reset value of the sync flops cannot be mistaken for a
        // stable input during priming.
        vld_d      = {vld_q[0], 1'b1};

        upd        = (sync2_q != filt_q) && (cnt_q == FILT_M1);
        settle     = !primed_q && vld_q[1] && (sync2_q == filt_q);

        filt_d     = upd ? sync2_q : filt_q;
        if ((sync2_q == filt_q) || upd) begin
            cnt_d = 4'd0;
        end else begin
            cnt_d = cnt_q + 4'd1;
        end

        pcnt_d     = settle ? (pcnt_q + 4'd1) : 4'd0;
        primed_d   = primed_q || upd || (settle && (pcnt_q == FILT_M1));

        idx_old    = gray_idx(filt_q);
        idx_new    = gray_idx(sync2_q);
        idx_diff   = idx_new - idx_old;

        // The priming update only adopts the value; it is never decoded.
        step_up_d  = upd && primed_q && (idx_diff == 2'd1);
        step_dn_d  = upd && primed_q && (idx_diff == 2'd3);
        step_bad_d = upd && primed_q && (idx_diff == 2'd2);

        en_d       = step_up_q || step_dn_q;
        dir_d      = step_up_q ? 1'b1 : (step_dn_q ? 1'b0 : dir_q);

        if (clr) begin
            pos_d = '0;
        end else if (step_up_q) begin
            pos_d = pos_q + 1'b1;
        end else if (step_dn_q) begin
            pos_d = pos_q - 1'b1;
        end else begin
            pos_d = pos_q;
        end

        err_d      = clr ? 1'b0 : (err_q || step_bad_q);
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= 2'b00;
            sync2_q    <= 2'b00;
            vld_q      <= 2'b00;
            filt_q     <= 2'b00;
            cnt_q      <= 4'd0;
            pcnt_q     <= 4'd0;
            primed_q   <= 1'b0;
            step_up_q  <= 1'b0;
            step_dn_q  <= 1'b0;
            step_bad_q <= 1'b0;
            en_q       <= 1'b0;
            dir_q      <= 1'b1;
            pos_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            vld_q      <= vld_d;
            filt_q     <= filt_d;
            cnt_q      <= cnt_d;
            pcnt_q     <= pcnt_d;
            primed_q   <= primed_d;
            step_up_q  <= step_up_d;
            step_dn_q  <= step_dn_d;
            step_bad_q <= step_bad_d;
            en_q       <= en_d;
            dir_q      <= dir_d;
            pos_q      <= pos_d;
            err_q      <= err_d;
        end
    end

    assign en_out       = en_q;
    assign up_dwn_n_out = dir_q;
    assign pos          = pos_q;
    assign err          = err_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Directed testbench for quad_decoder (FILT=2, POS_W=16, 10 ns clock).
module tb_quad_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_in = 1'b0;
    logic        b_in = 1'b0;
    logic        clr = 1'b0;
    logic        en_out;
    logic        up_dwn_n_out;
    logic [15:0] pos;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    quad_decoder #(.POS_W(16), .FILT(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .a_in         (a_in),
        .b_in         (b_in),
        .clr          (clr),
        .en_out       (en_out),
        .up_dwn_n_out (up_dwn_n_out),
        .pos          (pos),
        .err          (err)
    );

    always #5 clk = ~clk;

    task automatic check_state(input string name, input logic exp_dir,
                               input logic [15:0] exp_pos, input logic exp_err);
        n_checks++;
        if (pos !== exp_pos) begin
            n_fail++;
            $display("FAIL %s pos: got %h expected %h", name, pos, exp_pos);
        end
        n_checks++;
        if (up_dwn_n_out !== exp_dir) begin
            n_fail++;
            $display("FAIL %s dir: got %b expected %b", name, up_dwn_n_out, exp_dir);
        end
        n_checks++;
        if (err !== exp_err) begin
            n_fail++;
            $display("FAIL %s err: got %b expected %b", name, err, exp_err);
        end
    endtask

    // Watch en_out for a number of cycles and require it to stay low.
    task automatic watch_quiet(input string name, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (en_out !== 1'b0) begin
                n_fail++;
                $display("FAIL %s en_out cycle %0d: got %b expected 0", name, i, en_out);
            end
        end
    endtask

    // Drive a new A/B value, hold 8 cycles; a legal step pulses en_out
    // exactly at the 5th sample (edge E+4, E = edge capturing the change).
    task automatic do_step(input string name, input logic [1:0] ab, input logic exp_pulse,
                           input logic exp_dir, input logic [15:0] exp_pos, input logic exp_err);
        @(posedge clk); #1;
        {a_in, b_in} = ab;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (en_out !== (exp_pulse && (i == 4))) begin
                n_fail++;
                $display("FAIL %s en_out cycle %0d: got %b expected %b",
                         name, i, en_out, exp_pulse && (i == 4));
            end
        end
        check_state(name, exp_dir, exp_pos, exp_err);
        $display("step %s ab=%b en_pulse=%b dir=%b pos=%h err=%b",
                 name, ab, exp_pulse, up_dwn_n_out, pos, err);
    endtask

    task automatic do_clr(input string name, input logic exp_dir);
        @(posedge clk); #1;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        check_state(name, exp_dir, 16'h0000, 1'b0);
        $display("clr %s pos=%h err=%b", name, pos, err);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        {a_in, b_in} = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        n_checks++;
        if (en_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset en_out: got %b expected 0", en_out);
        end
        check_state("reset", 1'b1, 16'h0000, 1'b0);
        watch_quiet("prime00", 10);
        check_state("prime00", 1'b1, 16'h0000, 1'b0);
        $display("reset pos=%h err=%b dir=%b", pos, err, up_dwn_n_out);
    endtask

    task automatic test_up_sequence;
        do_step("up1", 2'b10, 1'b1, 1'b1, 16'd1, 1'b0);
        do_step("up2", 2'b11, 1'b1, 1'b1, 16'd2, 1'b0);
        do_step("up3", 2'b01, 1'b1, 1'b1, 16'd3, 1'b0);
        do_step("up4", 2'b00, 1'b1, 1'b1, 16'd4, 1'b0);
    endtask

    task automatic test_wrap;
        do_clr("clr_wrap", 1'b1);
        do_step("wrap_dn", 2'b01, 1'b1, 1'b0, 16'hFFFF, 1'b0);
        do_step("wrap_up", 2'b00, 1'b1, 1'b1, 16'h0000, 1'b0);
    endtask

    task automatic test_glitch;
        @(posedge clk); #1;
        {a_in, b_in} = 2'b10;
        @(posedge clk); #1;
        {a_in, b_in} = 2'b00;
        watch_quiet("glitch_a", 8);
        check_state("glitch_a", 1'b1, 16'h0000, 1'b0);
        @(posedge clk); #1;
        {a_in, b_in} = 2'b01;
        @(posedge clk); #1;
        {a_in, b_in} = 2'b00;
        watch_quiet("glitch_b", 8);
        check_state("glitch_b", 1'b1, 16'h0000, 1'b0);
        $display("glitch pos=%h", pos);
        // filt must still be 00, so 10 decodes as an up step
        do_step("post_glitch_up", 2'b10, 1'b1, 1'b1, 16'd1, 1'b0);
        do_step("post_glitch_dn", 2'b00, 1'b1, 1'b0, 16'd0, 1'b0);
    endtask

    task automatic test_illegal_and_clr;
        do_step("illegal", 2'b11, 1'b0, 1'b0, 16'd0, 1'b1);
        do_step("after_illegal", 2'b01, 1'b1, 1'b1, 16'd1, 1'b1);
        do_clr("clr_err", 1'b1);
        // clr coincident with the output edge of a legal step 01->00
        @(posedge clk); #1;
        {a_in, b_in} = 2'b00;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            clr = (i == 3);
            n_checks++;
            if (en_out !== (i == 4)) begin
                n_fail++;
                $display("FAIL clr_step en_out cycle %0d: got %b expected %b", i, en_out, i == 4);
            end
        end
        check_state("clr_step", 1'b1, 16'h0000, 1'b0);
        $display("clr_step pos=%h dir=%b", pos, up_dwn_n_out);
    endtask

    task automatic test_reset_mid;
        do_step("m1", 2'b10, 1'b1, 1'b1, 16'd1, 1'b0);
        do_step("m2", 2'b11, 1'b1, 1'b1, 16'd2, 1'b0);
        do_step("m3", 2'b01, 1'b1, 1'b1, 16'd3, 1'b0);
        do_step("m4", 2'b00, 1'b1, 1'b1, 16'd4, 1'b0);
        do_step("m5", 2'b10, 1'b1, 1'b1, 16'd5, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++;
        if (en_out !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid en_out: got %b expected 0", en_out);
        end
        check_state("rst_mid", 1'b1, 16'h0000, 1'b0);
        watch_quiet("reprime10", 10);
        check_state("reprime10", 1'b1, 16'h0000, 1'b0);
        $display("rst_mid pos=%h dir=%b", pos, up_dwn_n_out);
        do_step("after_rst", 2'b11, 1'b1, 1'b1, 16'd1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_up_sequence();
        test_wrap();
        test_glitch();
        test_illegal_and_clr();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
